// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants, colour key and RGB565 packing helper.
package vga_timing_pkg;
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int H_TOTAL      = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
  localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;
  localparam logic [15:0] TRANSPARENT_KEY = 16'hfff0;
  function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 4:1 pixel phase, X/Y scan counters, frame pulse and raw sync/visible flags.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       tick_o,
  output logic       frame_o,
  output logic       hsync_n_o,
  output logic       vsync_n_o,
  output logic       visible_o
);
  localparam int HT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_VIS + H_FP;
  localparam int VSS = V_VIS + V_FP;
  logic [1:0] phase_q;
  logic [9:0] x_q, y_q, x_d, y_d;
  logic       frame_q, x_end, y_end;
  assign x_end  = x_q == 10'(HT - 1);
  assign y_end  = y_q == 10'(VT - 1);
  assign tick_o = phase_q == 2'd3;
  always_comb begin
    x_d = x_end ? '0 : x_q + 10'd1;
    y_d = !x_end ? y_q : y_end ? '0 : y_q + 10'd1;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= 1'b0;
    end else begin
      phase_q <= phase_q + 2'd1;
      frame_q <= tick_o && x_end && y_end;
      if (tick_o) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign frame_o   = frame_q;
  assign hsync_n_o = !(x_q >= 10'(HSS) && x_q < 10'(HSS + H_SYNC));
  assign vsync_n_o = !(y_q >= 10'(VSS) && y_q < 10'(VSS + V_SYNC));
  assign visible_o = x_q < 10'(H_VIS) && y_q < 10'(V_VIS);
endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster source with priority/colour-key layer compositor and aligned colour/sync registers.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int          LAYERS      = 4,
  parameter logic [15:0] TRANSPARENT = TRANSPARENT_KEY,
  parameter logic [15:0] BACKGROUND  = 16'h0000,
  parameter int          H_VIS       = DEF_H_VIS,
  parameter int          H_FP        = DEF_H_FP,
  parameter int          H_SYNC      = DEF_H_SYNC,
  parameter int          H_BP        = DEF_H_BP,
  parameter int          V_VIS       = DEF_V_VIS,
  parameter int          V_FP        = DEF_V_FP,
  parameter int          V_SYNC      = DEF_V_SYNC,
  parameter int          V_BP        = DEF_V_BP
) (
  input  logic                   OriginalClk,
  input  logic                   ResetN,
  output logic [9:0]             XPosition,
  output logic [9:0]             YPosition,
  input  logic [16*LAYERS-1:0]   LayerData,
  output logic                   PixelTick,
  output logic                   FrameStart,
  output logic [3:0]             Red,
  output logic [3:0]             Green,
  output logic [3:0]             Blue,
  output logic                   HSync,
  output logic                   VSync
);
  logic        hs_n, vs_n, vis, hs_q, vs_q;
  logic [15:0] pix;
  logic [11:0] rgb_q;
  vga_timing_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i(OriginalClk),
    .rst_ni(ResetN),
    .x_o(XPosition),
    .y_o(YPosition),
    .tick_o(PixelTick),
    .frame_o(FrameStart),
    .hsync_n_o(hs_n),
    .vsync_n_o(vs_n),
    .visible_o(vis)
  );
  // Walk from lowest priority upward so the last opaque hit is the highest-priority layer.
  always_comb begin
    pix = BACKGROUND;
    for (int i = LAYERS - 1; i >= 0; i--)
      if (LayerData[16*i +: 16] != TRANSPARENT) pix = LayerData[16*i +: 16];
  end
  always_ff @(posedge OriginalClk) begin
    if (!ResetN) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (PixelTick) begin
      rgb_q <= vis ? rgb565_to_444(pix) : '0;
      hs_q  <= hs_n;
      vs_q  <= vs_n;
    end
  end
  assign {Red, Green, Blue} = rgb_q;
  assign HSync = hs_q;
  assign VSync = vs_q;
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: cycle-accurate raster model with a pixel scoreboard; shortened vertical timing keeps frames short.
module tb_vga_scan_ctrl;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = 800 * VT * 4;
  localparam logic [15:0] KEY = 16'hfff0;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] layers = '0;
  logic [9:0]  x, y;
  logic        tick, fs, hs, vs;
  logic [3:0]  r, g, b;
  logic [13:0] sb[$];
  logic [13:0] exp_px;
  int checks = 0, errors = 0, k = 0, nfs = 0, hl = 0;
  always #5 clk = ~clk;
  vga_scan_ctrl #(.V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .OriginalClk(clk),
    .ResetN(rst_n),
    .XPosition(x),
    .YPosition(y),
    .LayerData(layers),
    .PixelTick(tick),
    .FrameStart(fs),
    .Red(r),
    .Green(g),
    .Blue(b),
    .HSync(hs),
    .VSync(vs)
  );
  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
    end
  endtask
  function automatic logic [13:0] model_px(input int px, input int py, input logic [63:0] d);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 4; i++)
      if (d[16*i +: 16] != KEY) begin
        p = d[16*i +: 16];
        break;
      end
    if (px >= 640 || py >= VV) p = 16'h0000;
    return {p[15:12], p[10:7], p[4:1], !(px >= 656 && px < 752), !(py >= VV + VF && py < VV + VF + VS)};
  endfunction
  function automatic logic [15:0] rnd_word();
    int s;
    s = $urandom_range(3);
    return s < 2 ? KEY : s == 2 ? 16'hffff : 16'($urandom);
  endfunction
  task automatic run(input int n);
    int ph, px, py;
    for (int c = 0; c < n; c++) begin
      ph = k % 4;
      px = (k / 4) % 800;
      py = (k / 3200) % VT;
      if (ph == 0 && k > 0) begin
        if (sb.size() == 0) check("sb_empty", 36'd1, 36'd0);
        else exp_px = sb.pop_front();
      end
      check("raster", {x, y, tick, fs}, {px[9:0], py[9:0], ph == 3, k != 0 && k % FRAME == 0});
      check("pixel", {r, g, b, hs, vs}, exp_px);
      if (fs) nfs++;
      if (!hs) hl++;
      else if (hl > 0) begin
        check("hs_width", hl, 384);
        hl = 0;
      end
      if (ph == 3) sb.push_back(model_px(px, py, layers));
      else if (ph == 1) begin
        for (int i = 0; i < 4; i++) layers[16*i +: 16] = rnd_word();
        if ((px >= 636 && px < 644) || px < 8) layers = {4{16'hffff}};
      end
      k++;
      @(negedge clk);
    end
  endtask
  initial begin
    exp_px = 14'h0003;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(FRAME + 4 * 3200 + 1234);
    check("frames", nfs, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    hl = 0;
    sb.delete();
    exp_px = 14'h0003;
    run(3 * 3200 + 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Drives the 640×480@60 Hz VGA raster for the game display. It is the source end of the layer-render interface: it generates the `XPosition`/`YPosition` scan coordinates that every layer renderer consumes, and it samples each layer's 16-bit pixel back. It composites the layers by priority with colour-key transparency and drives the 12-bit VGA pins with matched sync timing.

## Interface
Parameters:
- `LAYERS`, 4: number of layer inputs. Layer 0 has the highest priority.
- `TRANSPARENT`, 16'hfff0: colour key that means "no pixel here" on a layer.
- `BACKGROUND`, 16'h0000: colour shown when every layer is transparent.
- `H_VIS/H_FP/H_SYNC/H_BP`, 640/16/96/48: horizontal timing in pixels.
- `V_VIS/V_FP/V_SYNC/V_BP`, 480/10/2/33: vertical timing in lines.

Ports:
- `OriginalClk`, in, 1: 100 MHz system clock. This is the only clock.
- `ResetN`, in, 1: synchronous reset, active-low.
- `XPosition`, out, 10: horizontal scan counter, 0..799.
- `YPosition`, out, 10: vertical scan counter, 0..524.
- `LayerData`, in, 16×LAYERS: concatenated layer outputs in RGB565. Layer i occupies bits [16i+15:16i].
- `PixelTick`, out, 1: one-cycle pulse on the last clock of each pixel period.
- `FrameStart`, out, 1: one-cycle pulse when the counters wrap to (0,0).
- `Red/Green/Blue`, out, 4 each: VGA colour outputs.
- `HSync/VSync`, out, 1 each: sync outputs, active-low.

## Operation
- A 2-bit phase counter `Phase` divides `OriginalClk` by 4, giving a 25 MHz pixel rate. `PixelTick = (Phase==3)`.
- `XPosition` and `YPosition` are registered. They change only on the edge that ends `Phase==3`, so each value is held stable for exactly 4 clocks. Layers must produce valid data for that coordinate by the `Phase==3` clock (3 clocks of settle time).
- Counter advance on a tick:
  - X increments.
  - At X=799, X wraps to 0 and Y increments.
  - At Y=524 with X=799, both wrap to 0 and `FrameStart` asserts for the following clock.
- Compositing happens on the `Phase==3` clock, for the current (X,Y):
  - The selected pixel is the lowest-index layer whose data is not equal to `TRANSPARENT`.
  - If every layer equals `TRANSPARENT`, the pixel is `BACKGROUND`.
  - If X≥640 or Y≥480 (blanking), the output pixel is forced to 0.
- RGB565 to 12-bit: `Red=p[15:12]`, `Green=p[10:7]`, `Blue=p[4:1]`.
- Sync generation:
  - `HSync=0` iff 656≤X<752.
  - `VSync=0` iff 490≤Y<492.
  - Both are computed from the same (X,Y) as the pixel and registered on the same edge.
- Reset values, applied on the first rising edge with `ResetN=0`:
  - `Phase`, `XPosition`, `YPosition` = 0
  - `Red/Green/Blue` = 0
  - `HSync`, `VSync` = 1
  - `PixelTick` = 0 (registered-equivalent), `FrameStart` = 0
- A reset asserted mid-frame restarts the raster at (0,0), phase 0. No partial state survives.

## Timing
- Coordinate (X,Y) is presented from clock edge E to edge E+4.
- RGB and sync outputs for (X,Y) update at edge E+4 and hold until E+8. Latency is one pixel period, and colour and sync stay aligned.
- `FrameStart` is high during the first clock of the period in which (0,0) is presented.
- Line = 3200 clocks. Frame = 420,000 pixels = 1,680,000 clocks.
- All outputs are registered. The only combinational input→output path is `LayerData` to the compositor register.

## Structure
- `vga_timing_pkg` holds:
  - the default timing constants;
  - the derived `H_TOTAL=800`, `V_TOTAL=525`, `H_SYNC_START=656`, `V_SYNC_START=490`;
  - the `TRANSPARENT` key.
- Sub-module `vga_timing_gen` contains the phase counter, the X/Y counters, `PixelTick`, `FrameStart`, and raw sync/visible flags.
- The top level contains the priority compositor and the output registers.

## Test plan
- Reset then free-run: first `PixelTick` at the 4th clock; X=1 at clock 4; X=799 → 0 with Y 0 → 1 after 3200 clocks; `FrameStart` repeats every 1,680,000 clocks.
- Sync widths: measure `HSync` low for 384 clocks starting when X=656 is latched to output (edge after X=656 ends); `VSync` low for exactly 2 lines (6400 clocks).
- Priority, checked at X=100,Y=100:
  - Layer0=`TRANSPARENT`, layer1=16'hF800 → Red=F, Green=0, Blue=0.
  - Layer0=16'h07E0 → Red=0, Green=F, Blue=0.
  - All layers `TRANSPARENT` → RGB equals `BACKGROUND`.
- Blanking: all layers 16'hFFFF, X≥640 or Y≥480 → RGB=0; at X=639,Y=479 → RGB=FFF.
- Latency: change layer data only during the period of X=200 → RGB changes for exactly 4 clocks starting 4 clocks after X=200 is presented.
- Mid-frame reset: at Y=300 hold `ResetN=0` for 1 clock → next edge outputs X=0,Y=0, HSync=VSync=1, RGB=0; the raster resumes normally.
